// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing controller for a datapath with one shared
// instruction/data memory. It is a Moore FSM whose strobes are gated by
// mem_ready (FETCH, MEMREAD, MEMWRITE) and zero (BEQ). It decodes lw, sw,
// R-type, I-type ALU, beq and jal, and counts retired instructions.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   opcode/funct3/funct7_5  instruction fields from the instruction register
//   zero              ALU zero flag
//   mem_ready         memory completes the access this cycle
//   mem_req/mem_write memory request and store strobe
//   adr_src           memory address select (0 PC, 1 ALUOut)
//   ir_write/pc_write/reg_write  datapath write enables
//   result_src, alu_src_a, alu_src_b, imm_src, alu_control  datapath selects
//   illegal_op        one-cycle pulse on an unknown opcode in DECODE
//   instr_retired     retired-instruction count (wraps)
//   state_dbg         current state encoding
module multicycle_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_src,
  output logic [2:0]       alu_control,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_retired,
  output logic [3:0]       state_dbg
);

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpJal = 7'b1101111;
  localparam logic [6:0] OpBeq = 7'b1100011;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       alu_op;
  logic             pc_update, branch, retire;
  logic             req_s, mwr_s, irw_s, rw_s, ill_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Next state and per-state controls
  always_comb begin
    state_d    = state_q;
    req_s      = 1'b0;
    mwr_s      = 1'b0;
    irw_s      = 1'b0;
    rw_s       = 1'b0;
    ill_s      = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    retire     = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    unique case (state_q)
      StFetch: begin
        req_s      = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          irw_s     = 1'b1;
          pc_update = 1'b1;
          state_d   = StDecode;
        end
      end
      StDecode: begin
        // Branch target PC+imm is computed here into ALUOut
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExecuteR;
          OpI:        state_d = StExecuteI;
          OpJal:      state_d = StJal;
          OpBeq:      state_d = StBeq;
          default: begin
            ill_s   = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OpSw) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        req_s   = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        result_src = 2'b01;
        rw_s       = 1'b1;
        retire     = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        req_s   = 1'b1;
        mwr_s   = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StExecuteR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StExecuteI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StJal: begin
        // PC <= ALUOut (target from DECODE) while ALU forms OldPC+4 link
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      StAluWb: begin
        rw_s    = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StBeq: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // ALU decoder
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (opcode[5] & funct7_5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    case (opcode)
      OpSw:    imm_src = 2'b01;
      OpBeq:   imm_src = 2'b10;
      OpJal:   imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Reset suppresses every strobe so an abandoned instruction writes nothing
  assign mem_req       = req_s & ~rst;
  assign mem_write     = mwr_s & ~rst;
  assign ir_write      = irw_s & ~rst;
  assign reg_write     = rw_s & ~rst;
  assign illegal_op    = ill_s & ~rst;
  assign pc_write      = (pc_update | (branch & zero)) & ~rst;
  assign instr_retired = cnt_q;
  assign state_dbg     = state_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing controller that turns the RV32I datapath into a multicycle machine with a single shared instruction/data memory.
- Moore FSM with Mealy gating on mem_ready and zero; drives every datapath select and write-enable.
- Decodes lw, sw, R-type, I-type ALU, beq and jal.
- Has a memory request/ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  store strobe, valid with mem_req
- adr_src  out  1  memory address select: 0 PC, 1 ALUOut
- ir_write  out  1  load instruction register and OldPC
- pc_write  out  1  load PC from result bus
- reg_write  out  1  register file write enable
- result_src  out  2  result select: 00 ALUOut, 01 mem read data, 10 ALU result
- alu_src_a  out  2  ALU A select: 00 PC, 01 OldPC, 10 rs1 reg
- alu_src_b  out  2  ALU B select: 00 rs2 reg, 01 imm_ext, 10 const 4
- imm_src  out  2  immediate format: 00 I, 01 S, 10 B, 11 J
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_op  out  1  one-cycle pulse, unknown opcode seen in DECODE
- instr_retired  out  CNT_W  count of completed instructions
- state_dbg  out  4  current state encoding

Behaviour:
- Reset (rst=1 at posedge):
  - state <= FETCH; instr_retired <= 0.
  - While rst=1, mem_req, mem_write, ir_write, pc_write, reg_write and illegal_op are forced 0 combinationally.
  - Reset mid-instruction abandons it; no write may be issued in the reset cycle.
- Default outputs every state: all enables 0; selects 00; alu_control 000.
- pc_write = pc_update | (branch & zero).
- imm_src is decoded from opcode in every state:
  - sw 01, beq 10, jal 11, else 00.
- alu_op per state:
  - 00 gives add.
  - 01 gives sub.
  - 10 decodes funct3:
    - 000: sub only if opcode[5]&funct7_5, else add.
    - 010: slt.
    - 110: or.
    - 111: and.
    - other: add.
- States:
  - FETCH:
    - Controls: mem_req=1, adr_src=0, a=00, b=10, alu_op 00, result_src=10.
    - If mem_ready: ir_write=1, pc_update=1, go to DECODE. Else hold with no write strobes.
  - DECODE:
    - Controls: a=01, b=01, alu_op 00 (branch target into ALUOut).
    - Transitions by opcode:
      - lw or sw: MEMADR.
      - R (0110011): EXECUTER.
      - I (0010011): EXECUTEI.
      - jal (1101111): JAL.
      - beq (1100011): BEQ.
      - other: illegal_op=1 and go to FETCH (not counted as retired).
  - MEMADR:
    - Controls: a=10, b=01, alu_op 00.
    - Go to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD:
    - Controls: mem_req=1, adr_src=1, result_src=00.
    - Hold until mem_ready, then go to MEMWB.
  - MEMWB:
    - Controls: result_src=01, reg_write=1.
    - Go to FETCH, retire.
  - MEMWRITE:
    - Controls: mem_req=1, mem_write=1, adr_src=1; held stable while waiting.
    - On mem_ready go to FETCH, retire.
  - EXECUTER:
    - Controls: a=10, b=00, alu_op 10.
    - Go to ALUWB.
  - EXECUTEI:
    - Controls: a=10, b=01, alu_op 10.
    - Go to ALUWB.
  - JAL:
    - Controls: a=01, b=10, alu_op 00, result_src=00, pc_update=1.
    - Go to ALUWB.
  - ALUWB:
    - Controls: result_src=00, reg_write=1.
    - Go to FETCH, retire.
  - BEQ:
    - Controls: a=10, b=00, alu_op 01, result_src=00, branch=1.
    - Go to FETCH, retire; pc_write only if zero.
- Retire: instr_retired increments by 1 on the transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It wraps modulo 2^CNT_W.
- Latency with zero-wait memory (mem_ready tied 1):
  - lw 5 cycles.
  - sw, R, I, jal 4 cycles.
  - beq 3 cycles.
  - Each wait cycle on mem_ready adds 1.
- mem_req never asserts outside FETCH, MEMREAD and MEMWRITE.
- Write strobes never assert in the same cycle as another memory-side strobe, except mem_write with mem_req.
- state_dbg encoding:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10.
  - Unreachable codes go to FETCH.

Test Plan:
- Reset then R-type or (opcode 0110011, funct3 110), mem_ready=1 -> states 0,1,6,8,0; alu_control 011 in EXECUTER; reg_write only in ALUWB; instr_retired=1.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEMREAD -> states 0,0,0,1,2,3,3,3,3,4,0; ir_write exactly once, only in the mem_ready cycle; result_src=01 in MEMWB.
- beq with zero=1, then again with zero=0 -> pc_write pulses in BEQ only when zero=1; alu_control 001; 3 cycles each; counter +2.
- sw (0100011) -> imm_src=01; mem_write and mem_req high together in MEMWRITE; reg_write never asserted.
- Opcode 1111111 -> illegal_op pulse in DECODE, back to FETCH, instr_retired unchanged; then sub (funct7_5=1, funct3 000) -> alu_control 001.
- rst asserted during MEMWRITE with mem_ready=0 -> mem_write/mem_req 0 that cycle; next cycle state_dbg=0, instr_retired=0.
